// File: rtl/microwave_timer.sv
// Cook-time countdown for the magnetron controller: keypad digits shift into a
// BCD MM:SS register while idle, and the register counts down once per second while enabled.
module microwave_timer #(
    parameter int CLK_HZ = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clearn,
    input  logic       en,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done,
    output logic       done_pulse
);

    localparam int PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRE_TC = PW'(CLK_HZ - 1);

    logic [15:0]   count_s;
    logic [15:0]   count_nxt_s;
    logic [PW-1:0] pre_r;
    logic [PW-1:0] pre_nxt_s;
    logic          count_nz_s;
    logic          key_ok_s;
    logic          pulse_nxt_s;
    logic          done_nxt_s;

    // One-second BCD decrement; the caller guarantees the count is nonzero.
    function automatic logic [15:0] bcd_dec(input logic [15:0] c);
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
        {mt, mo, st, so} = c;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    if (mt != 4'd0) begin
                        mt = mt - 4'd1;
                    end else begin
                        mt = 4'd0;
                    end
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    assign count_s    = {min_tens, min_ones, sec_tens, sec_ones};
    assign count_nz_s = (count_s != 16'd0);
    assign key_ok_s   = key_valid & ~en & (key_digit <= 4'd9);

    // Next-state count, prescaler and beeper pulse, in clear > entry > tick priority.
    always_comb begin
        count_nxt_s = count_s;
        pre_nxt_s   = pre_r;
        pulse_nxt_s = 1'b0;
        if (!clearn) begin
            count_nxt_s = 16'd0;
            pre_nxt_s   = '0;
        end else if (key_ok_s) begin
            count_nxt_s = {count_s[11:0], key_digit};
            pre_nxt_s   = '0;
        end else if (en && count_nz_s) begin
            if (pre_r == PRE_TC) begin
                count_nxt_s = bcd_dec(count_s);
                pre_nxt_s   = '0;
                pulse_nxt_s = (bcd_dec(count_s) == 16'd0);
            end else begin
                pre_nxt_s = pre_r + PW'(1);
            end
        end else begin
            pre_nxt_s = pre_r;
        end
        done_nxt_s = (count_nxt_s == 16'd0);
    end

    // Registered digits, prescaler and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {min_tens, min_ones, sec_tens, sec_ones} <= 16'd0;
            pre_r      <= '0;
            timer_done <= 1'b1;
            done_pulse <= 1'b0;
        end else begin
            {min_tens, min_ones, sec_tens, sec_ones} <= count_nxt_s;
            pre_r      <= pre_nxt_s;
            timer_done <= done_nxt_s;
            done_pulse <= pulse_nxt_s;
        end
    end

endmodule

// File: doc/microwave_timer.md
Name: microwave_timer

Overview:
- Cook-time countdown block feeding the magnetron controller's `timer_done` input.
- Takes that controller's latch output `Q` back as its run enable `en`.
- Keypad digits shift into a 4-digit BCD MM:SS register while idle; the register counts down once per second while `en`=1.
- Asserts `timer_done` whenever the count is 00:00, which resets the magnetron latch and blocks restart.

Parameters:
- CLK_HZ, 4, clock cycles per timer second (prescaler terminal count + 1); must be >= 2; synthesis builds override this with the board clock rate.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- clearn  input  1  active-low synchronous clear; sampled each clk.
- en  input  1  run enable, driven from magnetron latch Q.
- key_valid  input  1  one-cycle strobe: key_digit holds a new keypad digit.
- key_digit  input  4  BCD keypad digit 0-9; values 10-15 ignored.
- min_tens  output  4  BCD minutes tens.
- min_ones  output  4  BCD minutes ones.
- sec_tens  output  4  BCD seconds tens.
- sec_ones  output  4  BCD seconds ones.
- timer_done  output  1  level; 1 iff the displayed count is 00:00.
- done_pulse  output  1  one-cycle pulse when a countdown tick reaches 00:00 (beeper).

Behaviour:
- All outputs registered.
- Reset (async) values: all digits 0, prescaler 0, timer_done=1, done_pulse=0.
- Per-edge priority: reset > clearn=0 > key entry > countdown tick.
- clearn=0: all digits 0 and prescaler 0 on the next edge, regardless of en; done_pulse=0.
- Key entry accepted only when key_valid=1, en=0, key_digit<=9:
  - Shift left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_digit.
  - Prescaler cleared.
  - Overflowing min_tens is discarded.
- key_valid while en=1, or with key_digit>9: no effect.
- Seconds digits accept any 0-9 on entry (e.g. 0:75 legal); countdown handles them arithmetically.
- Prescaler, 0..CLK_HZ-1:
  - Increments each cycle with en=1 and count != 00:00.
  - Holds its value when en=0 (pause/resume keeps the partial second).
  - Wraps to 0 on tick.
- tick = en & (prescaler==CLK_HZ-1) & (count!=00:00). The count decrements at that same edge, i.e. on the CLK_HZ-th enabled cycle.
- BCD decrement, each digit borrowing only when it is 0:
  - sec_ones 0 -> 9 and borrow from sec_tens.
  - sec_tens 0 with borrow -> 5 and borrow from minutes.
  - min_ones 0 -> 9 and borrow from min_tens.
  - Never decrements below 00:00; 00:00 is never wrapped.
- timer_done registered from the next-state count: it equals 1 in the same cycle the digits show 00:00 and drops in the cycle the first nonzero digit appears.
- done_pulse=1 for exactly one cycle following a tick whose result is 00:00. Not asserted by clearn, reset, or entry of zeros.
- en=1 while count=00:00: nothing changes; timer_done stays 1 (controller must drop Q).
- en falling mid-second: digits and prescaler frozen. Rising again resumes from the frozen prescaler value.
- Reset asserted mid-run: immediate return to reset values; no done_pulse.

Test Plan (CLK_HZ=4):
- Reset -> all digits 0, timer_done=1, done_pulse=0. Keys 1,3,0 with en=0 -> display 01:30, timer_done=0 on the edge after the digit 1 is accepted.
- Load 00:02, en=1 continuously -> 00:01 after 4 cycles; 00:00 after 8 cycles. timer_done=1 and done_pulse=1 for one cycle at cycle 8; nothing changes thereafter.
- Load 01:00, en=1 for 4 cycles -> 00:59 (borrow chain). Load 10:00 -> 09:59. Load 0:75 -> 0:74 after one second.
- Load 00:05, en=1 for 2 cycles, en=0 for 10 cycles (digits and prescaler frozen), en=1 for 2 cycles -> 00:04 on the 4th enabled cycle.
- While running at 00:03, pulse key_valid with digit 7 -> ignored. clearn=0 for one cycle -> 00:00, timer_done=1, no done_pulse.
- key_digit=12 with key_valid=1, en=0 -> no change. Keys 1,2,3,4,5 -> 23:45 (first digit shifted out). Reset asserted mid-count -> all 0 immediately, asynchronously.
